wb_pipe_stage: RTL and testbench
================================

# wb_pipe_stage

Parametrised MEM→WB pipeline stage with a valid/ready handshake, two-entry skid buffer, flush, and breakpoint freeze with single-step release. It replaces the fixed-width, always-advancing MEM/WB register between data memory and the register-file write port. It also drives the final write-back mux and write enable, and counts back-pressure cycles for debug.

## Interface
Parameters:
- DATA_W, 32: width of memory read data and ALU result
- REG_AW, 5: destination register index width
- CNT_W, 16: stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- breakpoint  in  1  freeze: no transfers on either side while high
- step  in  1  one-cycle pulse; while breakpoint is high, permits exactly one output transfer
- flush  in  1  discard all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_memtoreg, in_regwrite  in  1 each  control bits
- in_mdout  in  DATA_W  memory read data
- in_alu_out  in  DATA_W  ALU result
- in_dreg  in  REG_AW  destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  write-back consumer accepts
- out_memtoreg, out_regwrite, out_mdout, out_alu_out, out_dreg  out  as inputs  head entry payload
- wb_data  out  DATA_W  out_memtoreg ? out_mdout : out_alu_out
- wb_we  out  1  out_valid & out_ready & out_regwrite & (out_dreg != 0)
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready

## Operation
- Storage: main register (drives out_*) and skid register. State is EMPTY, ONE, or TWO.
- accept = in_valid & in_ready; deq = out_valid & out_ready.
- in_ready = (state != TWO) & !breakpoint & !flush.
- out_valid = (state != EMPTY) & (!breakpoint | step).
- Transitions:
  - EMPTY: on accept, go to ONE and load main.
  - ONE: accept & !deq goes to TWO and loads skid. deq & !accept goes to EMPTY. accept & deq stays ONE and loads main with the new entry.
  - TWO: on deq, go to ONE with main <= skid. No accept is possible in TWO.
- flush has priority over everything. Next state is EMPTY and main/skid payloads clear to 0. A transfer presented in the same cycle does not occur, because in_ready is 0 under flush.
- breakpoint freezes state and payload. A step while breakpoint is high and state != EMPTY raises out_valid for that cycle only. If out_ready is also high, exactly one entry retires. A step with state EMPTY has no effect. step with breakpoint low is ignored.
- stall_cnt increments on out_valid & !out_ready and saturates at all-ones. It clears only on reset; flush does not clear it.
- Reset: state EMPTY, all payload registers 0, stall_cnt 0. Therefore out_valid=0, out_* = 0, wb_data=0, wb_we=0, and in_ready=1 unless breakpoint is high.

## Timing
- Latency: an entry accepted at edge N appears on out_* with out_valid=1 after edge N.
- Throughput: one entry per cycle with out_ready held high; the skid register is never used in that case.
- in_ready, out_valid, wb_data, and wb_we are combinational from state and from breakpoint/step/flush/out_ready. There is no combinational path from in_valid to in_ready.
- out_* payload is stable while out_valid & !out_ready.
- Reset assertion mid-transfer drops both entries immediately and asynchronously.

## Structure
- Shared package wb_pkg:
  - enum wb_state_e {EMPTY, ONE, TWO}
  - parameterised payload struct wb_payload_t {memtoreg, regwrite, mdout, alu_out, dreg}
  - WB_ZERO_REG constant (0)
- One natural sub-module: skid_buf2, the generic two-entry valid/ready buffer on a packed payload. wb_pipe_stage wraps it with the breakpoint/step/flush gating, the write-back mux, and stall_cnt.

## Test plan
- Reset then stream 4 entries with out_ready=1 (alu_out 1..4, dreg 3, regwrite=1, memtoreg=0) -> each appears 1 cycle after accept; wb_data 1..4; wb_we=1 each cycle; stall_cnt=0.
- Accept A, B with out_ready=0 -> state TWO; in_ready=0; stall_cnt counts 1,2,…; on out_ready=1, A then B retire in order.
- With 2 entries held, assert breakpoint for 5 cycles, then pulse step with out_ready=1 -> exactly one entry retires; out_valid returns to 0 next cycle; one entry remains.
- flush with TWO entries while in_valid=1 -> next cycle out_valid=0, out_*=0, state EMPTY; incoming entry not accepted.
- Entry with regwrite=1, dreg=0, memtoreg=1, mdout=0xDEADBEEF -> wb_data=0xDEADBEEF, wb_we=0.
- Hold out_valid=1 with out_ready=0 for 2^CNT_W+3 cycles (CNT_W=4) -> stall_cnt saturates at 0xF; rst_n low mid-cycle clears everything immediately.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM->WB pipeline stage.
package wb_pkg;

  // Occupancy of the two-entry stage buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wb_state_e;

  // Default widths.
  localparam int WB_DATA_W_DEF = 32;
  localparam int WB_REG_AW_DEF = 5;
  localparam int WB_CNT_W_DEF  = 16;

  // Register index that never gets written.
  localparam int WB_ZERO_REG = 0;

  // Packed payload width for the given data and register-index widths.
  // Field order is {memtoreg, regwrite, mdout, alu_out, dreg}.
  function automatic int wb_payload_w(input int data_w, input int reg_aw);
    return 2 + 2 * data_w + reg_aw;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic two-entry valid/ready buffer on a packed payload.
//
// Handshake: a transfer happens on a side exactly in a cycle where both
// valid and ready are high at the rising edge. in_ready and out_valid
// depend only on the occupancy state, so there is no combinational path
// from in_valid to in_ready or from out_ready to out_valid.
//
// The main register always holds the head entry and drives out_data.
// The skid register only fills when an entry arrives while the head is
// blocked. clr discards both entries and zeroes the payload registers.
module skid_buf2
  import wb_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data,
  output wb_state_e     state
);

  wb_state_e     r_state;
  wb_state_e     w_state_nxt;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;

  logic w_accept;
  logic w_deq;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_accept = in_valid & in_ready;
  assign w_deq    = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and payload-load decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (clr) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = ONE;
            w_load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && !w_deq) begin
            w_state_nxt = TWO;
            w_load_skid = 1'b1;
          end else if (w_deq && !w_accept) begin
            w_state_nxt = EMPTY;
          end else if (w_accept && w_deq) begin
            w_load_main_in = 1'b1;
          end
        end
        TWO: begin
          if (w_deq) begin
            w_state_nxt      = ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs from occupancy only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      TWO: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Payload registers: clear on clr, otherwise load as decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (clr) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= in_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

  assign out_data = r_main;
  assign state    = r_state;

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline stage: two-entry skid buffer with breakpoint freeze,
// single-step release and flush. It also produces the final write-back
// data/enable and a saturating back-pressure counter.
module wb_pipe_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W_DEF,
  parameter int REG_AW = WB_REG_AW_DEF,
  parameter int CNT_W  = WB_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              breakpoint,
  input  logic              step,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic [DATA_W-1:0] in_mdout,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [REG_AW-1:0] in_dreg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic [DATA_W-1:0] out_mdout,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [REG_AW-1:0] out_dreg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [CNT_W-1:0]  stall_cnt,
  output wb_state_e         dbg_state
);

  // Payload record; widths follow this instance's parameters.
  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic [DATA_W-1:0] mdout;
    logic [DATA_W-1:0] alu_out;
    logic [REG_AW-1:0] dreg;
  } wb_payload_t;

  localparam int PW = wb_payload_w(DATA_W, REG_AW);

  wb_payload_t w_in_pl;
  wb_payload_t w_out_pl;
  logic [PW-1:0] w_out_bits;

  logic w_in_open;
  logic w_out_open;
  logic w_sb_in_valid;
  logic w_sb_in_ready;
  logic w_sb_out_valid;
  logic w_sb_out_ready;
  logic w_stall;

  logic [CNT_W-1:0] r_stall_cnt;

  // Upstream side closes under breakpoint or flush.
  assign w_in_open  = !breakpoint && !flush;
  // Downstream side closes under breakpoint unless a step is presented.
  assign w_out_open = !breakpoint || step;

  assign w_sb_in_valid  = in_valid & w_in_open;
  assign w_sb_out_ready = out_ready & w_out_open;

  assign in_ready  = w_sb_in_ready & w_in_open;
  assign out_valid = w_sb_out_valid & w_out_open;

  assign w_in_pl.memtoreg = in_memtoreg;
  assign w_in_pl.regwrite = in_regwrite;
  assign w_in_pl.mdout    = in_mdout;
  assign w_in_pl.alu_out  = in_alu_out;
  assign w_in_pl.dreg     = in_dreg;

  skid_buf2 #(
    .PW(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .in_valid (w_sb_in_valid),
    .in_ready (w_sb_in_ready),
    .in_data  (w_in_pl),
    .out_valid(w_sb_out_valid),
    .out_ready(w_sb_out_ready),
    .out_data (w_out_bits),
    .state    (dbg_state)
  );

  assign w_out_pl     = wb_payload_t'(w_out_bits);
  assign out_memtoreg = w_out_pl.memtoreg;
  assign out_regwrite = w_out_pl.regwrite;
  assign out_mdout    = w_out_pl.mdout;
  assign out_alu_out  = w_out_pl.alu_out;
  assign out_dreg     = w_out_pl.dreg;

  // Final write-back mux and register-file write enable.
  always_comb begin
    wb_data = out_memtoreg ? out_mdout : out_alu_out;
    wb_we   = out_valid & out_ready & out_regwrite &
              (out_dreg != REG_AW'(WB_ZERO_REG));
  end

  assign w_stall = out_valid & !out_ready;

  // Back-pressure counter; saturates and survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage (CNT_W=4 so saturation is reachable).
module tb_wb_pipe_stage;
  import wb_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              breakpoint;
  logic              step;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_memtoreg;
  logic              in_regwrite;
  logic [DATA_W-1:0] in_mdout;
  logic [DATA_W-1:0] in_alu_out;
  logic [REG_AW-1:0] in_dreg;
  logic              out_valid;
  logic              out_ready;
  logic              out_memtoreg;
  logic              out_regwrite;
  logic [DATA_W-1:0] out_mdout;
  logic [DATA_W-1:0] out_alu_out;
  logic [REG_AW-1:0] out_dreg;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [CNT_W-1:0]  stall_cnt;
  wb_state_e         dbg_state;

  int n_vec;
  int n_err;

  wb_pipe_stage #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .breakpoint  (breakpoint),
    .step        (step),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_memtoreg (in_memtoreg),
    .in_regwrite (in_regwrite),
    .in_mdout    (in_mdout),
    .in_alu_out  (in_alu_out),
    .in_dreg     (in_dreg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_memtoreg(out_memtoreg),
    .out_regwrite(out_regwrite),
    .out_mdout   (out_mdout),
    .out_alu_out (out_alu_out),
    .out_dreg    (out_dreg),
    .wb_data     (wb_data),
    .wb_we       (wb_we),
    .stall_cnt   (stall_cnt),
    .dbg_state   (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic m2r, input logic rw,
                          input logic [DATA_W-1:0] md, input logic [DATA_W-1:0] alu,
                          input logic [REG_AW-1:0] dr);
    in_valid    = v;
    in_memtoreg = m2r;
    in_regwrite = rw;
    in_mdout    = md;
    in_alu_out  = alu;
    in_dreg     = dr;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    breakpoint = 1'b0;
    step = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;

    // Reset state.
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(EMPTY));
    @(negedge clk);
    rst_n = 1'b1;

    // Stream 4 entries at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_in(1'b1, 1'b0, 1'b1, 32'h0, DATA_W'(i), 5'd3);
      tick();
      chk("strm_out_valid", 64'(out_valid), 64'd1);
      chk("strm_wb_data", 64'(wb_data), 64'(i));
      chk("strm_wb_we", 64'(wb_we), 64'd1);
      chk("strm_state", 64'(dbg_state), 64'(ONE));
    end
    drive_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("strm_drain_state", 64'(dbg_state), 64'(EMPTY));
    chk("strm_stall_cnt", 64'(stall_cnt), 64'd0);

    // Back-pressure: A then B held, then both retire in order.
    out_ready = 1'b0;
    drive_in(1'b1, 1'b0, 1'b1, '0, 32'hA, 5'd4);
    tick();
    chk("bp_state_one", 64'(dbg_state), 64'(ONE));
    drive_in(1'b1, 1'b0, 1'b1, '0, 32'hB, 5'd4);
    tick();
    chk("bp_state_two", 64'(dbg_state), 64'(TWO));
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_stall_1", 64'(stall_cnt), 64'd1);
    chk("bp_head_a", 64'(out_alu_out), 64'hA);
    drive_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("bp_stall_2", 64'(stall_cnt), 64'd2);
    chk("bp_head_stable", 64'(out_alu_out), 64'hA);
    out_ready = 1'b1;
    #1;
    chk("bp_ret_a_we", 64'(wb_we), 64'd1);
    chk("bp_ret_a_data", 64'(wb_data), 64'hA);
    tick();
    chk("bp_head_b", 64'(out_alu_out), 64'hB);
    chk("bp_state_one_b", 64'(dbg_state), 64'(ONE));
    tick();
    chk("bp_drained", 64'(dbg_state), 64'(EMPTY));
    chk("bp_stall_hold", 64'(stall_cnt), 64'd2);

    // Breakpoint with two entries, then single step.
    out_ready = 1'b0;
    drive_in(1'b1, 1'b0, 1'b1, '0, 32'hC, 5'd5);
    tick();
    drive_in(1'b1, 1'b0, 1'b1, '0, 32'hD, 5'd5);
    tick();
    drive_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
    breakpoint = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("brk_out_valid", 64'(out_valid), 64'd0);
    chk("brk_in_ready", 64'(in_ready), 64'd0);
    chk("brk_wb_we", 64'(wb_we), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("brk_frozen_state", 64'(dbg_state), 64'(TWO));
    chk("brk_frozen_head", 64'(out_alu_out), 64'hC);
    chk("brk_stall", 64'(stall_cnt), 64'd3);
    step = 1'b1;
    #1;
    chk("step_out_valid", 64'(out_valid), 64'd1);
    chk("step_wb_we", 64'(wb_we), 64'd1);
    chk("step_wb_data", 64'(wb_data), 64'hC);
    tick();
    step = 1'b0;
    #1;
    chk("step_after_valid", 64'(out_valid), 64'd0);
    chk("step_after_state", 64'(dbg_state), 64'(ONE));
    chk("step_after_head", 64'(out_alu_out), 64'hD);
    breakpoint = 1'b0;
    tick();
    chk("step_drain", 64'(dbg_state), 64'(EMPTY));
    breakpoint = 1'b1;
    step = 1'b1;
    #1;
    chk("step_empty_valid", 64'(out_valid), 64'd0);
    tick();
    chk("step_empty_state", 64'(dbg_state), 64'(EMPTY));
    breakpoint = 1'b0;
    step = 1'b0;

    // Flush with two entries while a new one is offered.
    out_ready = 1'b0;
    drive_in(1'b1, 1'b1, 1'b1, 32'h11, 32'hE, 5'd6);
    tick();
    drive_in(1'b1, 1'b1, 1'b1, 32'h22, 32'hF, 5'd7);
    tick();
    chk("fl_pre_state", 64'(dbg_state), 64'(TWO));
    drive_in(1'b1, 1'b0, 1'b1, 32'h33, 32'h10, 5'd8);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    drive_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_state", 64'(dbg_state), 64'(EMPTY));
    chk("fl_alu_out", 64'(out_alu_out), 64'd0);
    chk("fl_mdout", 64'(out_mdout), 64'd0);
    chk("fl_dreg", 64'(out_dreg), 64'd0);
    chk("fl_ctrl", 64'({out_memtoreg, out_regwrite}), 64'd0);
    chk("fl_stall_kept", 64'(stall_cnt), 64'd5);

    // Write to register 0 is suppressed; memtoreg selects mdout.
    out_ready = 1'b1;
    drive_in(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h1234, 5'd0);
    tick();
    drive_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("r0_out_valid", 64'(out_valid), 64'd1);
    chk("r0_wb_data", 64'(wb_data), 64'hDEADBEEF);
    chk("r0_wb_we", 64'(wb_we), 64'd0);
    tick();
    chk("r0_drain", 64'(dbg_state), 64'(EMPTY));

    // Saturation, then asynchronous reset mid-cycle.
    out_ready = 1'b0;
    drive_in(1'b1, 1'b0, 1'b1, '0, 32'h77, 5'd9);
    tick();
    drive_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 19; i++) tick();
    chk("sat_stall_cnt", 64'(stall_cnt), 64'hF);
    chk("sat_head", 64'(out_alu_out), 64'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_state", 64'(dbg_state), 64'(EMPTY));
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_alu_out", 64'(out_alu_out), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
